shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential shift-and-add multiplier datapath driven by the Control stage.
//  Consumes Control's step strobe (Shot) and its counter flags (flag0 = first, flag32 = last).
//  Performs one multiply iteration per accepted step.
//  Presents a registered product and a one-cycle done pulse to the display/output stage.
// PARAMETERS
//  DATA_WIDTH   32                     operand width; product is 2*DATA_WIDTH
//  ITER_BITS    CeilLog2(DATA_WIDTH+1) iteration counter width
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             asynchronous, active-low reset
//  step_i       in   1             step strobe from Control.Shot; one iteration per cycle high
//  first_i      in   1             from Control.flag0; with step_i loads operands
//  last_i       in   1             from Control.flag32; with step_i publishes result
//  multiplicand_i in DATA_WIDTH    operand A, sampled on load only
//  multiplier_i in   DATA_WIDTH    operand B, sampled on load only
//  product_o    out  2*DATA_WIDTH  registered product, held until next publish
//  done_o       out  1             one-cycle pulse, cycle after publish
//  busy_o       out  1             high in RUN and HOLD
// BEHAVIOUR
//  Reset state:
//   - Reset (async, active-low) forces state=IDLE.
//   - Clears acc, A, B, iter, product_o, done_o and busy_o to 0.
//   - Reset mid-operation discards the operation and leaves no partial result.
//  FSM states: IDLE, RUN, HOLD, DONE (enum in package).
//   - Any state: step_i&&first_i -> load A<=multiplicand_i, B<=multiplier_i, acc<=0, iter<=0, go RUN.
//     first_i has priority over last_i and over an in-progress run (restart).
//   - RUN, step_i&&!first_i:
//     - if B[0]: acc[2W-1:W-1] <= {1'b0, acc[2W-1:W]} + A  (W+1-bit sum, carry kept).
//     - Then acc shifts right 1 and B>>=1; iter++.
//     - When iter reaches DATA_WIDTH-1 on this step, go HOLD.
//   - RUN, step_i&&last_i&&!first_i: last_i ignored (no publish); iteration proceeds normally.
//   - HOLD, step_i: no arithmetic.
//     - If last_i: product_o<=acc, go DONE.
//     - Otherwise stay in HOLD.
//   - DONE: done_o=1 for exactly this cycle, then IDLE unconditionally (or RUN if step_i&&first_i).
//   - IDLE, step_i without first_i: ignored.
//  Outputs:
//   - done_o is a registered Moore output (high only in DONE).
//   - busy_o = (state==RUN)||(state==HOLD).
//  Latency: load + DATA_WIDTH accepted steps + publish step; done_o rises 1 clk after publish step.
//  Steps outside first/last between HOLD entry and last (Control's 36-count spare steps) are ignored.
//  No overflow is possible: the 2W-bit product is exact.
// CONFIGURATION
//  SHIFT_ADD_MULT_SIGNED_EN defined:
//   - Operands are two's complement.
//   - Load stores magnitudes and sign_r = A[W-1]^B[W-1].
//   - Publish writes sign_r ? -acc : acc (2W-bit two's complement).
//   - Most negative operand magnitude 2^(W-1) is handled via W-bit unsigned magnitude.
//  Undefined: operands are unsigned; no sign register or negation logic is generated.
// STRUCTURE
//  Package mult_pkg:
//   - typedef enum logic [1:0] {IDLE,RUN,HOLD,DONE} mult_state_t.
//   - localparam DEFAULT_DATA_WIDTH=32.
//   - Function CeilLog2 (shared with Control; remove local copies).
//  Sub-module mult_add_shift:
//   - Combinational next-acc/next-B for one iteration.
//   - Keeps the FSM file purely sequential/control.
//  Everything else stays in this module.
// TESTING (DATA_WIDTH=32)
//  1) Basic multiply:
//     - Stimulus: load A=3,B=5; 32 steps; step with last_i.
//     - Response: product_o=64'h0F; done_o high 1 clk; busy_o low after.
//  2) Maximum operands:
//     - Stimulus: A=B=32'hFFFFFFFF.
//     - Response: product_o=64'hFFFFFFFE_00000001 (carry bit exercised).
//  3) Restart mid-run:
//     - Stimulus: load 7*9; after 10 steps, first_i with A=2,B=4; complete.
//     - Response: product_o=8, no done for 63.
//  4) Early last_i and reset mid-run:
//     - last_i at iter 5: no publish, product_o unchanged.
//     - Separately, reset low at iter 12: all outputs 0 next edge; later 6*6=36 correct.
//  5) Signed configuration:
//     - Stimulus: A=32'hFFFFFFFD(-3), B=7.
//     - SHIFT_ADD_MULT_SIGNED_EN defined: 64'hFFFFFFFF_FFFFFFEB.
//     - Undefined: 64'h00000006_FFFFFFEB.
//  6) Control integration:
//     - Stimulus: drive from Control (MAXIMUM_VALUE=36) with pulsed Start.
//     - Response: spare steps ignored; done_o once per 36-count wrap.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared multiplier/control package: FSM state encoding, default width, CeilLog2.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Smallest n with 2**n >= value; used for counter widths here and in Control.
    function automatic int unsigned CeilLog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_add_shift.sv
// One shift-and-add iteration: conditional add of A into the upper half, then shift right.
module mult_add_shift
    import mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [2*DATA_WIDTH-1:0] acc_next_c_o,
    output logic [DATA_WIDTH-1:0]   b_next_c_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned WIDE_W = PROD_W + 1;

    logic [DATA_WIDTH:0] sum_c;
    logic [WIDE_W-1:0]   wide_c;

    // Upper-half add keeps the carry so the full-ones case stays exact.
    assign sum_c = {1'b0, acc_i[PROD_W-1:DATA_WIDTH]} + {1'b0, a_i};

    // Select added or plain accumulator, then drop the retired LSB.
    always_comb begin
        wide_c = {1'b0, acc_i};
        if (b_i[0]) begin
            wide_c = {sum_c, acc_i[DATA_WIDTH-1:0]};
        end
        acc_next_c_o = PROD_W'(wide_c >> 1);
        b_next_c_o   = b_i >> 1;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier stepped by Control (Shot/flag0/flag32).
// Optional feature macro: SHIFT_ADD_MULT_SIGNED_EN (two's complement operands).
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ITER_BITS  = CeilLog2(DATA_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic [DATA_WIDTH-1:0]   multiplicand_i,
    input  logic [DATA_WIDTH-1:0]   multiplier_i,
    output logic [2*DATA_WIDTH-1:0] product_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    mult_state_t           state_q;
    logic [PROD_W-1:0]     acc_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [ITER_BITS-1:0]  iter_q;
    logic [PROD_W-1:0]     product_q;
    logic                  done_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] a_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic [PROD_W-1:0]     result_d;
    logic [PROD_W-1:0]     acc_next_c;
    logic [DATA_WIDTH-1:0] b_next_c;
    logic                  load_c;

    assign load_c = step_i && first_i;

    mult_add_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_add_shift (
        .acc_i        (acc_q),
        .a_i          (a_q),
        .b_i          (b_q),
        .acc_next_c_o (acc_next_c),
        .b_next_c_o   (b_next_c)
    );

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic sign_q;
    logic sign_d;

    // Operand magnitudes on load and sign-corrected result on publish.
    always_comb begin
        a_d      = multiplicand_i;
        b_d      = multiplier_i;
        sign_d   = multiplicand_i[DATA_WIDTH-1] ^ multiplier_i[DATA_WIDTH-1];
        result_d = acc_q;
        if (multiplicand_i[DATA_WIDTH-1]) begin
            a_d = ~multiplicand_i + DATA_WIDTH'(1);
        end
        if (multiplier_i[DATA_WIDTH-1]) begin
            b_d = ~multiplier_i + DATA_WIDTH'(1);
        end
        if (sign_q) begin
            result_d = ~acc_q + PROD_W'(1);
        end
    end

    // Product sign captured alongside the operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
        end else if (load_c) begin
            sign_q <= sign_d;
        end
    end
`else
    // Unsigned operands pass straight through.
    always_comb begin
        a_d      = multiplicand_i;
        b_d      = multiplier_i;
        result_d = acc_q;
    end
`endif

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            iter_q    <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_c) begin
                // Load wins over last_i and restarts any run in flight.
                a_q     <= a_d;
                b_q     <= b_d;
                acc_q   <= '0;
                iter_q  <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    RUN: begin
                        busy_q <= 1'b1;
                        if (step_i) begin
                            acc_q  <= acc_next_c;
                            b_q    <= b_next_c;
                            iter_q <= iter_q + ITER_BITS'(1);
                            if (iter_q == ITER_BITS'(DATA_WIDTH - 1)) begin
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        busy_q <= 1'b1;
                        if (step_i && last_i) begin
                            product_q <= result_d;
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign product_o = product_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (DATA_WIDTH=32).
module tb_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        step_i;
    logic        first_i;
    logic        last_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [63:0] product_o;
    logic        done_o;
    logic        busy_o;

    int checks;
    int failures;
    int pushed;
    int done_seen;
    logic [63:0] exp_q[$];

    shift_add_multiplier #(
        .DATA_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .step_i         (step_i),
        .first_i        (first_i),
        .last_i         (last_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .product_o      (product_o),
        .done_o         (done_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expected product.
    always @(negedge clk) begin
        if (reset && done_o) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got product %h expected no done", product_o);
            end else begin
                chk("scoreboard_product", product_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic l,
                         input logic [31:0] a, input logic [31:0] b);
        step_i         = s;
        first_i        = f;
        last_i         = l;
        multiplicand_i = a;
        multiplier_i   = b;
        tick();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    endtask

    task automatic expect_product(input logic [63:0] e);
        exp_q.push_back(e);
        pushed++;
    endtask

    // Publish step plus checks of the done pulse and its one-cycle width.
    task automatic publish(input string name, input logic [63:0] e);
        expect_product(e);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        chk({name, "_done_hi"}, 64'(done_o), 64'd1);
        chk({name, "_product"}, product_o, e);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk({name, "_done_lo"}, 64'(done_o), 64'd0);
        chk({name, "_busy_lo"}, 64'(busy_o), 64'd0);
    endtask

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] e);
        drive(1'b1, 1'b1, 1'b0, a, b);
        steps(32);
        chk({name, "_busy_hold"}, 64'(busy_o), 64'd1);
        publish(name, e);
    endtask

    // One 36-count Control wrap: load at 0, last at 33, spare steps at 34/35.
    task automatic ctrl_wrap(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        for (int cnt = 0; cnt < 36; cnt++) begin
            if (cnt == 33) expect_product(e);
            drive(1'b1, cnt == 0, cnt == 33, a, b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0; pushed = 0; done_seen = 0;
        reset = 1'b0;
        step_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        multiplicand_i = '0; multiplier_i = '0;
        #23;
        chk("reset_product", product_o, 64'h0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        reset = 1'b1;
        tick();

        // Step without first in IDLE is ignored.
        drive(1'b1, 1'b0, 1'b1, 32'd9, 32'd9);
        chk("idle_ignore_busy", 64'(busy_o), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        run_mul("basic", 32'd3, 32'd5, 64'h0F);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
`else
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
`endif

        // Restart mid-run: 7*9 is abandoned, only 2*4 publishes.
        drive(1'b1, 1'b1, 1'b0, 32'd7, 32'd9);
        steps(10);
        run_mul("restart", 32'd2, 32'd4, 64'd8);

        // Early last_i at iteration 5 is an ordinary step; no publish.
        drive(1'b1, 1'b1, 1'b0, 32'd10, 32'd10);
        steps(5);
        drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("early_last_product", product_o, 64'd8);
        chk("early_last_done", 64'(done_o), 64'd0);
        steps(26);
        // Spare steps in HOLD are ignored.
        steps(3);
        chk("hold_spare_busy", 64'(busy_o), 64'd1);
        publish("early_last", 64'd100);

        // Asynchronous reset mid-run clears everything.
        drive(1'b1, 1'b1, 1'b0, 32'd11, 32'd13);
        steps(12);
        step_i = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_product", product_o, 64'h0);
        chk("midreset_busy", 64'(busy_o), 64'd0);
        tick();
        chk("midreset_done", 64'(done_o), 64'd0);
        reset = 1'b1;
        tick();
        run_mul("after_reset", 32'd6, 32'd6, 64'd36);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        run_mul("signed", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        run_mul("signed", 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB);
`endif

        // Control-driven back-to-back wraps.
        ctrl_wrap(32'h1234, 32'h10, 64'h12340);
        ctrl_wrap(32'hABCD, 32'h3, 64'h20367);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("ctrl_product", product_o, 64'h20367);
        repeat (3) tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
